// File: rtl/cpu_defs.sv
// Shared CPU definitions: shifter opcodes, sequencer state encodings and the
// rule that turns a requested amount into a per-bit step count.
package cpu_defs;

  localparam logic [2:0] OP_SHL  = 3'b000;
  localparam logic [2:0] OP_SHR  = 3'b001;
  localparam logic [2:0] OP_SHRA = 3'b010;
  localparam logic [2:0] OP_ROL  = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  function automatic logic op_valid(input logic [2:0] op);
    return (op <= OP_ROR);
  endfunction

  // Rotates wrap modulo 32; shifts saturate at 32 since any further step is a no-op.
  function automatic logic [5:0] eff_count(input logic [2:0] op, input logic [31:0] amount);
    logic [5:0] n;
    n = 6'd0;
    case (op)
      OP_ROL, OP_ROR:          n = {1'b0, amount[4:0]};
      OP_SHL, OP_SHR, OP_SHRA: n = (amount > 32'd32) ? 6'd32 : amount[5:0];
      default:                 n = 6'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/shift_step_32.sv
// One-bit shift/rotate step for the sequencer datapath; invalid ops pass through.
module shift_step_32
  import cpu_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  // NOTE: the default assignment first keeps this combinational block latch-free.
  always_comb begin
    data_o = data_i;
    case (op_i)
      OP_SHL:  data_o = {data_i[WIDTH-2:0], 1'b0};
      OP_SHR:  data_o = {1'b0, data_i[WIDTH-1:1]};
      OP_SHRA: data_o = {data_i[WIDTH-1], data_i[WIDTH-1:1]};
      OP_ROL:  data_o = {data_i[WIDTH-2:0], data_i[WIDTH-1]};
      OP_ROR:  data_o = {data_i[0], data_i[WIDTH-1:1]};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/shift_seq_32.sv
// Multi-cycle 32-bit shifter/rotator: one bit per clock, done pulse on completion.
module shift_seq_32
  import cpu_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result
);

  logic [1:0]       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [5:0]       count_q, count_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] step_data;
  logic [5:0]       n_req;

  shift_step_32 #(.WIDTH(WIDTH)) u_step (
    .op_i   (op_q),
    .data_i (work_q),
    .data_o (step_data)
  );

  assign n_req = eff_count(op, operand_b);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    work_d   = work_q;
    count_d  = count_q;
    result_d = result_q;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = op;
          work_d  = operand_a;
          count_d = n_req;
          if (n_req == 6'd0) begin
            result_d = operand_a;
            err_d    = !op_valid(op);
            state_d  = ST_DONE;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        work_d  = step_data;
        count_d = count_q - 6'd1;
        if (count_q == 6'd1) begin
          result_d = step_data;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_SHL;
      work_q   <= '0;
      count_q  <= 6'd0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      work_q   <= work_d;
      count_q  <= count_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign err    = err_q;
  assign result = result_q;

endmodule

// File: doc/shift_seq_32.md
SHIFT_SEQ_32 -- requirements
Module: shift_seq_32

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have port clock  input  1  rising-edge clock for all state.
REQ-003 SHALL have port clear  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port op  input  3  000 SHL, 001 SHR, 010 SHRA, 011 ROL, 100 ROR, 101-111 invalid.
REQ-006 SHALL have port operand_a  input  32  value to shift or rotate.
REQ-007 SHALL have port operand_b  input  32  unsigned shift/rotate amount.
REQ-008 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-009 SHALL have port done  output  1  one-cycle pulse; result is valid.
REQ-010 SHALL have port err  output  1  high with done when op was invalid.
REQ-011 SHALL have port result  output  32  registered result; held until the next accepted start.

Function
REQ-012 SHALL implement states IDLE, SHIFT and DONE, registered and encoded per the shared package.
REQ-013 SHALL accept start only in IDLE; in IDLE with start=1 at edge T it SHALL capture op, operand_a into a work register and the effective count n into a 6-bit counter.
REQ-014 SHALL compute n as operand_b[4:0] for ROL/ROR, min(operand_b, 32) for SHL/SHR/SHRA, and 0 for invalid op.
REQ-015 SHALL go IDLE->DONE at edge T when n=0, copying operand_a to result; otherwise it SHALL go IDLE->SHIFT.
REQ-016 SHALL, in SHIFT, move the work register one bit per edge: SHL fills with 0, SHR fills with 0, SHRA replicates bit 31, ROL moves bit 31 into bit 0, ROR moves bit 0 into bit 31; each such edge SHALL decrement the count.
REQ-017 SHALL, on the SHIFT edge that brings the count to 0, load the shifted value into result and go to DONE; done therefore rises n+1 edges after the accepting edge for n>=1, or 1 edge after for n=0.
REQ-018 SHALL drive done=1 for exactly one cycle in DONE, then return to IDLE unconditionally.
REQ-019 SHALL ignore start while busy; no queuing of requests.
REQ-020 SHALL latch err=1 in DONE only for an invalid op; err SHALL be 0 in all other cycles.
REQ-021 SHALL make results bit-identical to single-cycle rotate semantics ((A<<k)|(A>>(32-k)), with k=0 giving A); SHL/SHR SHALL yield 0 for amounts >=32, and SHRA SHALL yield 32 copies of bit 31.
REQ-022 SHALL ignore changes on operand_a, operand_b and op after acceptance.

Reset
REQ-023 SHALL, with clear=1 at an edge in any state including mid-SHIFT, set state=IDLE, busy=0, done=0, err=0, result=0 and counter=0, and discard the operation in progress.
REQ-024 SHALL give clear priority over start in the same cycle.

Structure
REQ-025 SHALL take the op encodings and state encodings as constants from the shared CPU package (cpu_defs).
REQ-026 SHALL instantiate one combinational sub-module, shift_step_32 (one-bit step per op), inside the SHIFT datapath.

Verification
REQ-027 SHALL cover: ROL with A=0x80000001, B=4, start -> done after 5 edges, result=0x00000018, err=0.
REQ-028 SHALL cover: ROR with A=0x00000001, B=33 (amount 1 after modulo) -> done after 2 edges, result=0x80000000.
REQ-029 SHALL cover: SHRA with A=0x80000000, B=40 -> count saturates at 32, done after 33 edges, result=0xFFFFFFFF; SHL with the same A and B -> result=0.
REQ-030 SHALL cover: op=110, A=0x12345678, B=7 -> done after 1 edge, err=1, result=0x12345678.
REQ-031 SHALL cover: ROL with B=0 and A=0xDEADBEEF -> done after 1 edge, result=0xDEADBEEF; a second start pulsed while busy is ignored (exactly one done).
REQ-032 SHALL cover: clear asserted on the 3rd SHIFT edge of a B=10 operation -> next cycle busy=0, done=0, result=0; a new start is then accepted normally.
